// File: rtl/cache_axi_arbiter.sv
// Shares one AXI master port between icache reads and dcache reads/writes.
// One outstanding read (AR/R) and one outstanding write (AW/W/B), run as independent FSMs.
module cache_axi_arbiter #(
  parameter int ID_W      = 4,
  parameter int ICACHE_ID = 0,
  parameter int DCACHE_ID = 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            i_rd_req,
  input  logic [2:0]      i_rd_type,
  input  logic [31:0]     i_rd_addr,
  output logic            i_rd_rdy,
  output logic            i_ret_valid,
  output logic            i_ret_last,
  output logic [31:0]     i_ret_data,
  input  logic            d_rd_req,
  input  logic [2:0]      d_rd_type,
  input  logic [31:0]     d_rd_addr,
  output logic            d_rd_rdy,
  output logic            d_ret_valid,
  output logic            d_ret_last,
  output logic [31:0]     d_ret_data,
  input  logic            d_wr_req,
  input  logic [2:0]      d_wr_type,
  input  logic [31:0]     d_wr_addr,
  input  logic [3:0]      d_wr_wstrb,
  input  logic [127:0]    d_wr_data,
  output logic            d_wr_rdy,
  output logic [ID_W-1:0] arid,
  output logic [31:0]     araddr,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic            arvalid,
  input  logic            arready,
  input  logic [ID_W-1:0] rid,
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready,
  output logic [ID_W-1:0] awid,
  output logic [31:0]     awaddr,
  output logic [7:0]      awlen,
  output logic [2:0]      awsize,
  output logic [1:0]      awburst,
  output logic            awvalid,
  input  logic            awready,
  output logic [31:0]     wdata,
  output logic [3:0]      wstrb,
  output logic            wlast,
  output logic            wvalid,
  input  logic            wready,
  input  logic [ID_W-1:0] bid,
  input  logic [1:0]      bresp,
  input  logic            bvalid,
  output logic            bready
);
  localparam logic [ID_W-1:0] IID  = ID_W'(ICACHE_ID);
  localparam logic [ID_W-1:0] DID  = ID_W'(DCACHE_ID);
  localparam logic [1:0]      INCR = 2'b01;

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} wstate_t;
  rstate_t rstate;
  wstate_t wstate;

  function automatic logic [7:0] len_of(input logic [2:0] t);
    return (t == 3'b100) ? 8'd3 : 8'd0;
  endfunction
  function automatic logic [2:0] size_of(input logic [2:0] t);
    return (t == 3'b100) ? 3'd2 : {1'b0, t[1:0]};
  endfunction

  // write buffer
  logic [31:0]  wb_addr;
  logic [7:0]   wb_len;
  logic [2:0]   wb_size;
  logic [3:0]   wb_strb;
  logic [127:0] wb_data;
  logic [1:0]   wcnt;

  logic        r_is_d;
  logic        d_hazard, d_grant;
  logic [2:0]  sel_type;
  logic [31:0] sel_addr;

  // A dcache read of the line sitting in the write buffer must wait for the B response.
  assign d_hazard = (wstate != W_IDLE) && (d_rd_addr[31:4] == wb_addr[31:4]);
  assign d_grant  = d_rd_req && !d_hazard;
  assign sel_type = d_grant ? d_rd_type : i_rd_type;
  assign sel_addr = d_grant ? d_rd_addr : i_rd_addr;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rstate  <= R_IDLE;
      arvalid <= 1'b0;
      arid    <= '0;
      araddr  <= '0;
      arlen   <= '0;
      arsize  <= '0;
      r_is_d  <= 1'b0;
    end else begin
      case (rstate)
        R_IDLE: if (d_grant || i_rd_req) begin
          rstate  <= R_AR;
          arvalid <= 1'b1;
          r_is_d  <= d_grant;
          arid    <= d_grant ? DID : IID;
          araddr  <= sel_addr;
          arlen   <= len_of(sel_type);
          arsize  <= size_of(sel_type);
        end
        R_AR: if (arready) begin
          rstate  <= R_DATA;
          arvalid <= 1'b0;
        end
        R_DATA: if (rvalid && rlast) rstate <= R_IDLE;
        default: rstate <= R_IDLE;
      endcase
    end
  end

  assign arburst     = INCR;
  assign i_rd_rdy    = (rstate == R_AR) && arready && !r_is_d;
  assign d_rd_rdy    = (rstate == R_AR) && arready && r_is_d;
  assign rready      = (rstate == R_DATA);
  assign i_ret_valid = rready && rvalid && (rid == IID);
  assign d_ret_valid = rready && rvalid && (rid == DID);
  assign i_ret_last  = i_ret_valid && rlast;
  assign d_ret_last  = d_ret_valid && rlast;
  assign i_ret_data  = i_ret_valid ? rdata : '0;
  assign d_ret_data  = d_ret_valid ? rdata : '0;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wstate   <= W_IDLE;
      d_wr_rdy <= 1'b0;
      wcnt     <= '0;
      wb_addr  <= '0;
      wb_len   <= '0;
      wb_size  <= '0;
      wb_strb  <= '0;
      wb_data  <= '0;
    end else begin
      case (wstate)
        W_IDLE: begin
          d_wr_rdy <= 1'b1;
          if (d_wr_req && d_wr_rdy) begin
            wstate   <= W_AW;
            d_wr_rdy <= 1'b0;
            wb_addr  <= d_wr_addr;
            wb_len   <= len_of(d_wr_type);
            wb_size  <= size_of(d_wr_type);
            wb_strb  <= (d_wr_type == 3'b100) ? 4'hf : d_wr_wstrb;
            wb_data  <= d_wr_data;
          end
        end
        W_AW: if (awready) wstate <= W_DATA;
        W_DATA: if (wready) begin
          wcnt <= wcnt + 2'd1;
          if (wlast) begin
            wcnt   <= '0;
            wstate <= W_RESP;
          end
        end
        W_RESP: if (bvalid) begin
          wstate   <= W_IDLE;
          d_wr_rdy <= 1'b1;
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  assign awvalid = (wstate == W_AW);
  assign awid    = DID;
  assign awaddr  = wb_addr;
  assign awlen   = wb_len;
  assign awsize  = wb_size;
  assign awburst = INCR;
  assign wvalid  = (wstate == W_DATA);
  assign wdata   = wb_data[{wcnt, 5'd0} +: 32];
  assign wstrb   = wb_strb;
  assign wlast   = wvalid && ({6'd0, wcnt} == wb_len);
  assign bready  = (wstate == W_RESP);

  // Responses carry no information this block acts on.
  logic unused_resp;
  assign unused_resp = ^{rresp, bid, bresp};
endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Scoreboard bench for cache_axi_arbiter: tasks drive a hand-played AXI slave and
// compare returned/written words against a queue of expected words.
module tb_cache_axi_arbiter;
  logic         clk = 1'b0;
  logic         resetn;
  logic         i_rd_req, d_rd_req, d_wr_req;
  logic [2:0]   i_rd_type, d_rd_type, d_wr_type;
  logic [31:0]  i_rd_addr, d_rd_addr, d_wr_addr;
  logic [3:0]   d_wr_wstrb;
  logic [127:0] d_wr_data;
  logic         i_rd_rdy, i_ret_valid, i_ret_last, d_rd_rdy, d_ret_valid, d_ret_last, d_wr_rdy;
  logic [31:0]  i_ret_data, d_ret_data;
  logic [3:0]   arid, rid, awid, bid;
  logic [31:0]  araddr, rdata, awaddr, wdata;
  logic [7:0]   arlen, awlen;
  logic [2:0]   arsize, awsize;
  logic [1:0]   arburst, awburst, rresp, bresp;
  logic         arvalid, arready, rlast, rvalid, rready, awvalid, awready;
  logic [3:0]   wstrb;
  logic         wlast, wvalid, wready, bvalid, bready;

  int vecs = 0;
  int errs = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  cache_axi_arbiter #(.ID_W(4), .ICACHE_ID(0), .DCACHE_ID(1)) dut (
    .clk(clk), .resetn(resetn),
    .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr), .i_rd_rdy(i_rd_rdy),
    .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last), .i_ret_data(i_ret_data),
    .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr), .d_rd_rdy(d_rd_rdy),
    .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last), .d_ret_data(d_ret_data),
    .d_wr_req(d_wr_req), .d_wr_type(d_wr_type), .d_wr_addr(d_wr_addr),
    .d_wr_wstrb(d_wr_wstrb), .d_wr_data(d_wr_data), .d_wr_rdy(d_wr_rdy),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic set_r(input logic v, input logic [3:0] id, input logic [31:0] d, input logic l);
    rvalid = v; rid = id; rdata = d; rlast = l;
  endtask

  // slave plays out n R beats without checking
  task automatic drain_r(input logic [3:0] id, input int n);
    for (int k = 0; k < n; k++) begin
      set_r(1'b1, id, 32'(k), k == n - 1);
      tick;
    end
    set_r(1'b0, 4'd0, 32'd0, 1'b0);
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (2) tick;
    @(negedge clk);
    vecs++;
    if ({arvalid, awvalid, wvalid, rready, bready, i_rd_rdy, d_rd_rdy, d_wr_rdy,
         i_ret_valid, i_ret_last, d_ret_valid, d_ret_last} !== 12'h0) begin
      errs++; $display("FAIL reset_outputs: got nonzero valid/rdy/ret, want all 0");
    end
    tick; resetn = 1'b1; tick;
    @(negedge clk);
    vecs++;
    if (d_wr_rdy !== 1'b1) begin errs++; $display("FAIL reset_wr_rdy: got %b want 1", d_wr_rdy); end
    tick;
  endtask

  task automatic test_icache_line;
    logic [31:0] e;
    i_rd_req = 1'b1; i_rd_type = 3'b100; i_rd_addr = 32'h1c000000;
    tick;
    @(negedge clk);
    vecs++;
    if ({arvalid, arid, araddr, arlen, arsize, arburst} !== {1'b1, 4'd0, 32'h1c000000, 8'd3, 3'd2, 2'b01}) begin
      errs++; $display("FAIL ic_ar: got v=%b id=%0h a=%h len=%0d size=%0d", arvalid, arid, araddr, arlen, arsize);
    end
    arready = 1'b1; #1;
    vecs++;
    if ({i_rd_rdy, d_rd_rdy} !== 2'b10) begin errs++; $display("FAIL ic_rdy: got %b%b want 10", i_rd_rdy, d_rd_rdy); end
    tick; arready = 1'b0; i_rd_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_r(1'b1, 4'd0, 32'hA0000000 + k, k == 3);
      exp_q.push_back(32'hA0000000 + k);
      @(negedge clk);
      e = exp_q.pop_front();
      vecs++;
      if ({i_ret_valid, i_ret_last, i_ret_data, d_ret_valid, i_rd_rdy, rready} !== {1'b1, k == 3, e, 1'b0, 1'b0, 1'b1}) begin
        errs++; $display("FAIL ic_beat%0d: got v=%b last=%b d=%h dv=%b want d=%h", k, i_ret_valid, i_ret_last, i_ret_data, d_ret_valid, e);
      end
      tick;
    end
    set_r(1'b0, 4'd0, 32'd0, 1'b0);
    @(negedge clk);
    vecs++;
    if ({rready, arvalid} !== 2'b00) begin errs++; $display("FAIL ic_idle: got rready=%b arvalid=%b want 0 0", rready, arvalid); end
    tick;
  endtask

  task automatic test_priority;
    logic [31:0] e;
    i_rd_req = 1'b1; i_rd_type = 3'b100; i_rd_addr = 32'h1c000040;
    d_rd_req = 1'b1; d_rd_type = 3'b100; d_rd_addr = 32'h00002000;
    tick;
    @(negedge clk);
    vecs++;
    if ({arvalid, arid, araddr} !== {1'b1, 4'd1, 32'h00002000}) begin
      errs++; $display("FAIL prio_ar: got id=%0h a=%h want 1 00002000", arid, araddr);
    end
    arready = 1'b1; #1;
    vecs++;
    if ({i_rd_rdy, d_rd_rdy} !== 2'b01) begin errs++; $display("FAIL prio_rdy: got %b%b want 01", i_rd_rdy, d_rd_rdy); end
    tick; arready = 1'b0; d_rd_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_r(1'b1, 4'd1, 32'hD0000000 + k, k == 3);
      exp_q.push_back(32'hD0000000 + k);
      @(negedge clk);
      e = exp_q.pop_front();
      vecs++;
      if ({d_ret_valid, d_ret_last, d_ret_data, i_ret_valid, arvalid} !== {1'b1, k == 3, e, 1'b0, 1'b0}) begin
        errs++; $display("FAIL dc_beat%0d: got v=%b last=%b d=%h iv=%b want d=%h", k, d_ret_valid, d_ret_last, d_ret_data, i_ret_valid, e);
      end
      tick;
    end
    set_r(1'b0, 4'd0, 32'd0, 1'b0);
    @(negedge clk);
    vecs++;
    if (arvalid !== 1'b0) begin errs++; $display("FAIL prio_gap: got arvalid=%b want 0", arvalid); end
    tick;
    @(negedge clk);
    vecs++;
    if ({arvalid, arid, araddr} !== {1'b1, 4'd0, 32'h1c000040}) begin
      errs++; $display("FAIL prio_ic_ar: got v=%b id=%0h a=%h want 1 0 1c000040", arvalid, arid, araddr);
    end
    arready = 1'b1; tick; arready = 1'b0; i_rd_req = 1'b0;
    drain_r(4'd0, 4);
    tick;
  endtask

  task automatic test_victim_write;
    logic [127:0] line;
    int cyc;
    line = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
    d_wr_req = 1'b1; d_wr_type = 3'b100; d_wr_addr = 32'h00001230; d_wr_wstrb = 4'h0; d_wr_data = line;
    for (int k = 0; k < 4; k++) exp_q.push_back(line[32*k +: 32]);
    tick; d_wr_req = 1'b0;
    @(negedge clk);
    vecs++;
    if ({awvalid, awid, awaddr, awlen, awsize, awburst, d_wr_rdy, wvalid} !==
        {1'b1, 4'd1, 32'h00001230, 8'd3, 3'd2, 2'b01, 1'b0, 1'b0}) begin
      errs++; $display("FAIL vw_aw: got v=%b id=%0h a=%h len=%0d size=%0d rdy=%b", awvalid, awid, awaddr, awlen, awsize, d_wr_rdy);
    end
    awready = 1'b1; tick; awready = 1'b0;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 40) begin
      @(negedge clk);
      wready = (cyc % 3 != 1);
      if (wvalid) begin
        vecs++;
        if ({wdata, wlast, wstrb} !== {exp_q[0], exp_q.size() == 1, 4'hf}) begin
          errs++; $display("FAIL vw_w: got d=%h last=%b strb=%h want d=%h", wdata, wlast, wstrb, exp_q[0]);
        end
        if (wready) void'(exp_q.pop_front());
      end
      tick; cyc++;
    end
    wready = 1'b0;
    vecs++;
    if (exp_q.size() != 0) begin errs++; $display("FAIL vw_timeout: got %0d beats left want 0", exp_q.size()); end
    exp_q.delete();
    @(negedge clk);
    vecs++;
    if ({wvalid, bready, d_wr_rdy} !== 3'b010) begin errs++; $display("FAIL vw_resp: got %b%b%b want 010", wvalid, bready, d_wr_rdy); end
    bvalid = 1'b1; tick; bvalid = 1'b0;
    @(negedge clk);
    vecs++;
    if ({bready, d_wr_rdy} !== 2'b01) begin errs++; $display("FAIL vw_done: got %b%b want 01", bready, d_wr_rdy); end
    tick;
  endtask

  task automatic test_raw;
    logic seen;
    int n;
    d_wr_req = 1'b1; d_wr_type = 3'b100; d_wr_addr = 32'h00001230; d_wr_data = {4{32'hCAFEF00D}};
    tick; d_wr_req = 1'b0;
    d_rd_req = 1'b1; d_rd_type = 3'b010; d_rd_addr = 32'h00002230;
    tick;
    @(negedge clk);
    vecs++;
    if ({arvalid, arid, araddr, arlen, arsize} !== {1'b1, 4'd1, 32'h00002230, 8'd0, 3'd2}) begin
      errs++; $display("FAIL raw_other: got v=%b a=%h len=%0d size=%0d want 1 00002230 0 2", arvalid, araddr, arlen, arsize);
    end
    arready = 1'b1; tick; arready = 1'b0; d_rd_req = 1'b0;
    drain_r(4'd1, 1);
    d_rd_addr = 32'h00001234; d_rd_req = 1'b1;
    seen = 1'b0;
    repeat (2) begin @(negedge clk); seen |= arvalid; tick; end
    awready = 1'b1; tick; awready = 1'b0;
    wready = 1'b1;
    repeat (4) begin @(negedge clk); seen |= arvalid; tick; end
    wready = 1'b0;
    repeat (3) begin @(negedge clk); seen |= arvalid; tick; end
    vecs++;
    if (seen !== 1'b0) begin errs++; $display("FAIL raw_block: got arvalid=1 during write want 0"); end
    bvalid = 1'b1; tick; bvalid = 1'b0;
    n = 0;
    while (!arvalid && n < 5) begin tick; n++; end
    @(negedge clk);
    vecs++;
    if ({arvalid, araddr} !== {1'b1, 32'h00001234}) begin
      errs++; $display("FAIL raw_release: got v=%b a=%h want 1 00001234", arvalid, araddr);
    end
    arready = 1'b1; tick; arready = 1'b0; d_rd_req = 1'b0;
    drain_r(4'd1, 1);
    tick;
  endtask

  task automatic test_byte_store;
    d_wr_req = 1'b1; d_wr_type = 3'b000; d_wr_addr = 32'h00004002; d_wr_wstrb = 4'b0100;
    d_wr_data = {96'd0, 32'h00AB0000};
    exp_q.push_back(32'h00AB0000);
    tick; d_wr_req = 1'b0;
    @(negedge clk);
    vecs++;
    if ({awvalid, awaddr, awlen, awsize} !== {1'b1, 32'h00004002, 8'd0, 3'd0}) begin
      errs++; $display("FAIL bs_aw: got v=%b a=%h len=%0d size=%0d want 1 00004002 0 0", awvalid, awaddr, awlen, awsize);
    end
    awready = 1'b1; tick; awready = 1'b0;
    @(negedge clk);
    vecs++;
    if ({wvalid, wdata, wlast, wstrb} !== {1'b1, exp_q[0], 1'b1, 4'b0100}) begin
      errs++; $display("FAIL bs_w: got v=%b d=%h last=%b strb=%b want 1 00ab0000 1 0100", wvalid, wdata, wlast, wstrb);
    end
    void'(exp_q.pop_front());
    wready = 1'b1; tick; wready = 1'b0;
    @(negedge clk);
    vecs++;
    if ({wvalid, bready} !== 2'b01) begin errs++; $display("FAIL bs_resp: got %b%b want 01", wvalid, bready); end
    bvalid = 1'b1; tick; bvalid = 1'b0;
    tick;
  endtask

  task automatic test_reset_mid;
    logic bad;
    i_rd_req = 1'b1; i_rd_type = 3'b100; i_rd_addr = 32'h1c000080;
    tick;
    bad = 1'b0;
    repeat (5) begin @(negedge clk); if (!arvalid || i_rd_rdy) bad = 1'b1; tick; end
    vecs++;
    if (bad !== 1'b0) begin errs++; $display("FAIL rm_hold: got arvalid drop or rdy while arready low"); end
    resetn = 1'b0;
    @(negedge clk);
    vecs++;
    if ({i_rd_rdy, d_rd_rdy} !== 2'b00) begin errs++; $display("FAIL rm_rdy: got %b%b want 00", i_rd_rdy, d_rd_rdy); end
    tick; i_rd_req = 1'b0;
    @(negedge clk);
    vecs++;
    if ({arvalid, i_rd_rdy, rready} !== 3'b000) begin errs++; $display("FAIL rm_idle: got %b%b%b want 000", arvalid, i_rd_rdy, rready); end
    resetn = 1'b1; tick; tick;
  endtask

  initial begin
    resetn = 1'b0;
    i_rd_req = 0; i_rd_type = 0; i_rd_addr = 0;
    d_rd_req = 0; d_rd_type = 0; d_rd_addr = 0;
    d_wr_req = 0; d_wr_type = 0; d_wr_addr = 0; d_wr_wstrb = 0; d_wr_data = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
    test_reset;
    test_icache_line;
    test_priority;
    test_victim_write;
    test_raw;
    test_byte_store;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish within 200000 time units");
    $fatal(1);
  end
endmodule
